cdns_ip6185_dll_phy: RTL and testbench

//  Digital lock controller for the Cadence IP6185 DLL PHY, running at 1.2 GHz.

---
 rtl/cdns_ip6185_dll_phy_pkg.sv | 21 ++
 rtl/dll_phy_phase_filter.sv | 41 ++++
 rtl/cdns_ip6185_dll_phy.sv | 160 ++++++++++++++++
 tb/tb_cdns_ip6185_dll_phy.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cdns_ip6185_dll_phy_pkg.sv
// Shared types and default constants for the IP6185 DLL PHY lock controller.
package cdns_ip6185_dll_phy_pkg;

  localparam int DEF_CODE_W       = 8;
  localparam int DEF_LOCK_TOGGLES = 4;
  localparam int DEF_FILT_DEPTH   = 4;
  localparam int DEF_LOCK_DRIFT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Signed accumulator must hold +/-depth with headroom for the pre-clear sum.
  function automatic int acc_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/dll_phy_phase_filter.sv
// Tracking filter: integrates phase-detector samples and emits a one-cycle
// inc/dec request when the accumulator reaches +/-FILT_DEPTH.
module dll_phy_phase_filter
  import cdns_ip6185_dll_phy_pkg::*;
#(
  parameter int FILT_DEPTH = DEF_FILT_DEPTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic step_i,
  input  logic late_i,
  output logic inc_o,
  output logic dec_o
);

  localparam int ACC_W = acc_width(FILT_DEPTH);
  localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] POS_TH = ACC_W'(FILT_DEPTH);
  localparam logic signed [ACC_W-1:0] NEG_TH = -POS_TH;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;

  always_comb begin
    acc_sum = late_i ? (acc_q - ONE) : (acc_q + ONE);
    inc_o   = step_i && !clear_i && (acc_sum == POS_TH);
    dec_o   = step_i && !clear_i && (acc_sum == NEG_TH);
    acc_d   = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = (inc_o || dec_o) ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/cdns_ip6185_dll_phy.sv
// IP6185 DLL PHY lock controller: linear search to lock, then filtered tracking.
// Optional lock-loss detection in TRACK is enabled by DLL_PHY_LOCK_LOSS_DET_EN.
module cdns_ip6185_dll_phy
  import cdns_ip6185_dll_phy_pkg::*;
#(
  parameter int CODE_W       = DEF_CODE_W,
  parameter int LOCK_TOGGLES = DEF_LOCK_TOGGLES,
`ifdef DLL_PHY_LOCK_LOSS_DET_EN
  parameter int LOCK_DRIFT   = DEF_LOCK_DRIFT,
`endif
  parameter int FILT_DEPTH   = DEF_FILT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [CODE_W-1:0] start_code_i,
  input  logic              pd_valid_i,
  input  logic              pd_late_i,
  output logic [CODE_W-1:0] delay_code_o,
  output logic [CODE_W-1:0] lock_code_o,
  output logic              locked_o,
  output logic              error_o,
  output logic [2:0]        state_o
);

  localparam int TOG_W = $clog2(LOCK_TOGGLES + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] lock_code_q, lock_code_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  logic              dir_late_q, dir_late_d;
  logic              dir_valid_q, dir_valid_d;

  logic              filt_clear, filt_step, filt_inc, filt_dec;
  logic              sat_hit;
  logic [TOG_W-1:0]  tog_rev;

  assign filt_clear = !enable_i || (state_q != ST_TRACK);
  assign filt_step  = enable_i && pd_valid_i && (state_q == ST_TRACK);

  dll_phy_phase_filter #(
    .FILT_DEPTH (FILT_DEPTH)
  ) u_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (filt_clear),
    .step_i  (filt_step),
    .late_i  (pd_late_i),
    .inc_o   (filt_inc),
    .dec_o   (filt_dec)
  );

`ifdef DLL_PHY_LOCK_LOSS_DET_EN
  logic [CODE_W-1:0] drift;
  assign drift = (code_d >= lock_code_q) ? (code_d - lock_code_q) : (lock_code_q - code_d);
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    lock_code_d = lock_code_q;
    locked_d    = locked_q;
    error_d     = error_q;
    tog_d       = tog_q;
    dir_late_d  = dir_late_q;
    dir_valid_d = dir_valid_q;
    sat_hit     = pd_late_i ? (code_q == '0) : (code_q == CODE_MAX);
    tog_rev     = (dir_valid_q && (pd_late_i != dir_late_q)) ? (tog_q + TOG_W'(1)) : '0;

    if (!enable_i) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          code_d      = start_code_i;
          tog_d       = '0;
          dir_valid_d = 1'b0;
          state_d     = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (pd_valid_i) begin
            if (sat_hit) begin
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              code_d      = pd_late_i ? (code_q - 1'b1) : (code_q + 1'b1);
              dir_late_d  = pd_late_i;
              dir_valid_d = 1'b1;
              tog_d       = tog_rev;
              if (tog_rev == TOG_W'(LOCK_TOGGLES)) begin
                state_d     = ST_TRACK;
                locked_d    = 1'b1;
                lock_code_d = code_d;
                tog_d       = '0;
              end
            end
          end
        end
        ST_TRACK: begin
          // Saturation clips the code but keeps tracking; the error flag is sticky.
          if (filt_inc) begin
            if (code_q == CODE_MAX) error_d = 1'b1;
            else                    code_d  = code_q + 1'b1;
          end else if (filt_dec) begin
            if (code_q == '0) error_d = 1'b1;
            else              code_d  = code_q - 1'b1;
          end
`ifdef DLL_PHY_LOCK_LOSS_DET_EN
          if ((filt_inc || filt_dec) && (drift > CODE_W'(LOCK_DRIFT))) begin
            locked_d    = 1'b0;
            tog_d       = '0;
            dir_valid_d = 1'b0;
            state_d     = ST_SEARCH;
          end
`endif
        end
        ST_ERROR: begin
          locked_d = 1'b0;
          error_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      lock_code_q <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      tog_q       <= '0;
      dir_late_q  <= 1'b0;
      dir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      lock_code_q <= lock_code_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      tog_q       <= tog_d;
      dir_late_q  <= dir_late_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  assign delay_code_o = code_q;
  assign lock_code_o  = lock_code_q;
  assign locked_o     = locked_q;
  assign error_o      = error_q;
  assign state_o      = {1'b0, state_q};

endmodule

// File: tb/tb_cdns_ip6185_dll_phy.sv
// Table-driven bench for the IP6185 DLL PHY lock controller, plus hand-written
// reset and (with DLL_PHY_LOCK_LOSS_DET_EN) lock-loss sequences.
`timescale 1ns/1ps
module tb_cdns_ip6185_dll_phy;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] start_code_i = 8'h00;
  logic       pd_valid_i = 1'b0;
  logic       pd_late_i = 1'b0;
  logic [7:0] delay_code_o;
  logic [7:0] lock_code_o;
  logic       locked_o;
  logic       error_o;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  cdns_ip6185_dll_phy dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .start_code_i (start_code_i),
    .pd_valid_i   (pd_valid_i),
    .pd_late_i    (pd_late_i),
    .delay_code_o (delay_code_o),
    .lock_code_o  (lock_code_o),
    .locked_o     (locked_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic       late;
    logic [7:0] start;
    logic [7:0] code;
    logic [7:0] lcode;
    logic       lck;
    logic       err;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic vld, input logic late,
                              input logic [7:0] start, input logic [7:0] code,
                              input logic [7:0] lcode, input logic lck,
                              input logic err, input logic [2:0] st);
    vec_t v;
    v.en = en; v.vld = vld; v.late = late; v.start = start; v.code = code;
    v.lcode = lcode; v.lck = lck; v.err = err; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%02h, expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [7:0] code, input logic [7:0] lcode,
                         input logic lck, input logic err, input logic [2:0] st);
    chk("delay_code", idx, delay_code_o, code);
    chk("lock_code",  idx, lock_code_o,  lcode);
    chk("locked",     idx, {7'd0, locked_o}, {7'd0, lck});
    chk("error",      idx, {7'd0, error_o},  {7'd0, err});
    chk("state",      idx, {5'd0, state_o},  {5'd0, st});
    $display("step %0d: en=%0b vld=%0b late=%0b -> code=%02h lock_code=%02h locked=%0b err=%0b st=%0d",
             idx, enable_i, pd_valid_i, pd_late_i, delay_code_o, lock_code_o, locked_o, error_o, state_o);
  endtask

  task automatic apply(input logic en, input logic vld, input logic late, input logic [7:0] start);
    @(negedge clk_i);
    enable_i = en; pd_valid_i = vld; pd_late_i = late; start_code_i = start;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // en vld late start | code lcode lck err st
    add(0,0,0,8'h00, 8'h00,8'h00,0,0,0);
    add(1,0,0,8'h40, 8'h40,8'h00,0,0,1);
    add(1,1,1,8'h00, 8'h3F,8'h00,0,0,1);
    add(1,0,0,8'h00, 8'h3F,8'h00,0,0,1);
    add(1,1,0,8'h00, 8'h40,8'h00,0,0,1);
    add(1,1,1,8'h00, 8'h3F,8'h00,0,0,1);
    add(1,1,0,8'h00, 8'h40,8'h00,0,0,1);
    add(1,1,1,8'h00, 8'h3F,8'h3F,1,0,2);
    for (int i = 0; i < 3; i++) add(1,1,0,8'h00, 8'h3F,8'h3F,1,0,2);
    add(1,1,0,8'h00, 8'h40,8'h3F,1,0,2);
    for (int i = 0; i < 6; i++) add(1,1,(i >= 3),8'h00, 8'h40,8'h3F,1,0,2);
    for (int i = 0; i < 3; i++) add(1,1,1,8'h00, 8'h40,8'h3F,1,0,2);
    add(1,1,1,8'h00, 8'h3F,8'h3F,1,0,2);
    add(0,1,0,8'h00, 8'h3F,8'h3F,0,0,0);
    add(0,1,1,8'h00, 8'h3F,8'h3F,0,0,0);
    add(1,0,0,8'hFE, 8'hFE,8'h3F,0,0,1);
    add(1,1,0,8'h00, 8'hFF,8'h3F,0,0,1);
    add(1,1,0,8'h00, 8'hFF,8'h3F,0,1,3);
    add(1,1,0,8'h00, 8'hFF,8'h3F,0,1,3);
    add(0,0,0,8'h00, 8'hFF,8'h3F,0,0,0);
    add(1,0,0,8'h00, 8'h00,8'h3F,0,0,1);
    add(1,1,1,8'h00, 8'h00,8'h3F,0,1,3);
    add(0,0,0,8'h00, 8'h00,8'h3F,0,0,0);
    add(1,0,0,8'hFF, 8'hFF,8'h3F,0,0,1);
    add(1,1,1,8'h00, 8'hFE,8'h3F,0,0,1);
    add(1,1,0,8'h00, 8'hFF,8'h3F,0,0,1);
    add(1,1,1,8'h00, 8'hFE,8'h3F,0,0,1);
    add(1,1,0,8'h00, 8'hFF,8'h3F,0,0,1);
    add(1,1,1,8'h00, 8'hFE,8'hFE,1,0,2);
    for (int i = 0; i < 3; i++) add(1,1,0,8'h00, 8'hFE,8'hFE,1,0,2);
    add(1,1,0,8'h00, 8'hFF,8'hFE,1,0,2);
    for (int i = 0; i < 3; i++) add(1,1,0,8'h00, 8'hFF,8'hFE,1,0,2);
    add(1,1,0,8'h00, 8'hFF,8'hFE,1,1,2);

    repeat (2) @(posedge clk_i);
    #1;
    chk_all(-1, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].vld, vecs[i].late, vecs[i].start);
      chk_all(i, vecs[i].code, vecs[i].lcode, vecs[i].lck, vecs[i].err, vecs[i].st);
    end

    // Asynchronous reset while tracking: outputs clear without a clock edge.
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk_all(100, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    pd_valid_i = 1'b0;
    enable_i = 1'b0;

`ifdef DLL_PHY_LOCK_LOSS_DET_EN
    apply(1, 0, 0, 8'h40);
    for (int i = 0; i < 5; i++) apply(1, 1, (i % 2 == 0), 8'h00);
    chk_all(200, 8'h3F, 8'h3F, 1, 0, 2);
    for (int i = 0; i < 35; i++) apply(1, 1, 0, 8'h00);
    chk_all(201, 8'h47, 8'h3F, 1, 0, 2);
    apply(1, 1, 0, 8'h00);
    chk_all(202, 8'h48, 8'h3F, 0, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
